// File: rtl/datapath_responder_pkg.sv
// datapath_responder_pkg: constants shared by the datapath and the control block.
// Contents: control-word bit indices, the all-deasserted control word,
// instruction opcodes, the bus source enum and a multi-driver detector.
package datapath_responder_pkg;

  localparam int CTRL_W = 15;

  localparam int C_PC_INC          = 14;
  localparam int C_PC_EN           = 13;
  localparam int C_PC_LOAD         = 12;
  localparam int C_MAR_ADDR_LOAD_N = 11;
  localparam int C_MAR_MEM_LOAD_N  = 10;
  localparam int C_RAM_EN_N        = 9;
  localparam int C_RAM_LOAD_N      = 8;
  localparam int C_IR_LOAD_N       = 7;
  localparam int C_IR_EN_N         = 6;
  localparam int C_REGA_LOAD_N     = 5;
  localparam int C_REGA_EN         = 4;
  localparam int C_ADDER_SUB       = 3;
  localparam int C_ALU_EN          = 2;
  localparam int C_REGB_LOAD_N     = 1;
  localparam int C_OUT_LOAD_N      = 0;

  // Every enable deasserted and every active-low load held high.
  localparam logic [CTRL_W-1:0] CTRL_NOP = 15'h0FE3;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_PC,
    SRC_RAM,
    SRC_IR,
    SRC_A,
    SRC_ALU
  } bus_src_e;

  // True when two or more request bits are set (clearing the lowest set bit leaves something).
  function automatic logic multi_drive(input logic [4:0] d);
    return |(d & (d - 5'd1));
  endfunction

endpackage

// File: rtl/datapath_ram.sv
// datapath_ram: 16x8 RAM with asynchronous read and an external programming port.
// Ports: clk; rst (blocks datapath writes only, contents are never cleared);
// prog_we/prog_addr/prog_data external write, wins over the datapath write;
// wr_en/addr/wdata datapath write at the MAR address; rdata = mem[addr].
module datapath_ram (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       wr_en,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] mem [16];
  // Programming stays live during reset so memory can be loaded before a run.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    else if (wr_en && !rst) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/datapath_responder.sv
// datapath_responder: 8-bit bus datapath (PC, MAR, MDR, RAM, IR, A, B, ALU, OUT) driven by a control word.
// Ports: clk, rst (async, active-high); ctrl control word sampled on rising clk;
// prog_we/prog_addr/prog_data RAM programming; opcode = IR[7:4]; out_value = OUT;
// bus = current bus value; bus_conflict = more than one bus driver enabled.
// Optional: define DATAPATH_FLAGS_EN to add registered carry/zero flags (flag_c, flag_z).
module datapath_responder
  import datapath_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              prog_we,
  input  logic [3:0]        prog_addr,
  input  logic [7:0]        prog_data,
  output logic [3:0]        opcode,
  output logic [7:0]        out_value,
  output logic [7:0]        bus,
  output logic              bus_conflict
`ifdef DATAPATH_FLAGS_EN
  ,
  output logic              flag_c,
  output logic              flag_z
`endif
);
  logic [3:0] pc_q, pc_d, mar_q, mar_d;
  logic [7:0] mdr_q, mdr_d, ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic [7:0] ram_rd, alu;
  logic [4:0] drv;
  logic       sub, ram_wr;
  bus_src_e   src;

  assign sub    = ctrl[C_ADDER_SUB];
  assign ram_wr = !ctrl[C_RAM_LOAD_N];
  // Driver requests in priority order, highest at the MSB.
  assign drv = {ctrl[C_PC_EN], !ctrl[C_RAM_EN_N], !ctrl[C_IR_EN_N], ctrl[C_REGA_EN], ctrl[C_ALU_EN]};

`ifdef DATAPATH_FLAGS_EN
  logic alu_c, flag_c_q, flag_c_d, flag_z_q, flag_z_d;
  // Subtract as A + ~B + 1 so the ninth bit reads as "no borrow".
  assign {alu_c, alu} = {1'b0, a_q} + {1'b0, sub ? ~b_q : b_q} + {8'h00, sub};
`else
  assign alu = a_q + (sub ? ~b_q : b_q) + {7'h00, sub};
`endif

  datapath_ram u_ram (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .wr_en     (ram_wr),
    .addr      (mar_q),
    .wdata     (mdr_q),
    .rdata     (ram_rd)
  );

  always_comb begin
    src = drv[4] ? SRC_PC : drv[3] ? SRC_RAM : drv[2] ? SRC_IR :
          drv[1] ? SRC_A : drv[0] ? SRC_ALU : SRC_NONE;
    bus = src == SRC_PC  ? {4'h0, pc_q} :
          src == SRC_RAM ? ram_rd :
          src == SRC_IR  ? {4'h0, ir_q[3:0]} :
          src == SRC_A   ? a_q :
          src == SRC_ALU ? alu : 8'h00;
    // Registers load from the bus built from their current values, so a register
    // that drives and loads in the same cycle keeps its old value visible until the edge.
    pc_d  = ctrl[C_PC_LOAD] ? bus[3:0] : ctrl[C_PC_INC] ? pc_q + 4'd1 : pc_q;
    mar_d = ctrl[C_MAR_ADDR_LOAD_N] ? mar_q : bus[3:0];
    mdr_d = ctrl[C_MAR_MEM_LOAD_N] ? mdr_q : bus;
    ir_d  = ctrl[C_IR_LOAD_N] ? ir_q : bus;
    a_d   = ctrl[C_REGA_LOAD_N] ? a_q : bus;
    b_d   = ctrl[C_REGB_LOAD_N] ? b_q : bus;
    out_d = ctrl[C_OUT_LOAD_N] ? out_q : bus;
  end

  assign bus_conflict = !rst && multi_drive(drv);
  assign opcode       = rst ? 4'h0 : ir_q[7:4];
  assign out_value    = rst ? 8'h00 : out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= 4'h0;
      mar_q <= 4'h0;
      mdr_q <= 8'h00;
      ir_q  <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      out_q <= 8'h00;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  // Flags follow only an ALU result that actually reaches A over the bus.
  always_comb begin
    flag_c_d = (src == SRC_ALU && !ctrl[C_REGA_LOAD_N]) ? alu_c : flag_c_q;
    flag_z_d = (src == SRC_ALU && !ctrl[C_REGA_LOAD_N]) ? (alu == 8'h00) : flag_z_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`endif
endmodule

// File: tb/tb_datapath_responder.sv
// tb_datapath_responder: scoreboard bench with a behavioural datapath model and randomized control words.
module tb_datapath_responder;
  localparam logic [14:0] NOP    = 15'h0FE3;
  localparam logic [14:0] PC_INC = 15'h4000, PC_EN  = 15'h2000, PC_LD  = 15'h1000;
  localparam logic [14:0] MAR_LD = 15'h0800, MDR_LD = 15'h0400, RAM_EN = 15'h0200;
  localparam logic [14:0] RAM_WR = 15'h0100, IR_LD  = 15'h0080, IR_EN  = 15'h0040;
  localparam logic [14:0] A_LD   = 15'h0020, A_EN   = 15'h0010, SUB    = 15'h0008;
  localparam logic [14:0] ALU_EN = 15'h0004, B_LD   = 15'h0002, OUT_LD = 15'h0001;

  logic        clk = 1'b0, rst = 1'b1, prog_we = 1'b0;
  logic [14:0] ctrl = NOP;
  logic [3:0]  prog_addr = 4'h0, opcode;
  logic [7:0]  prog_data = 8'h00, out_value, bus;
  logic        bus_conflict;
`ifdef DATAPATH_FLAGS_EN
  logic        flag_c, flag_z;
`endif

  always #5 clk = ~clk;

  datapath_responder dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl         (ctrl),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .opcode       (opcode),
    .out_value    (out_value),
    .bus          (bus),
    .bus_conflict (bus_conflict)
`ifdef DATAPATH_FLAGS_EN
    ,
    .flag_c       (flag_c),
    .flag_z       (flag_z)
`endif
  );

  typedef struct packed {
    logic [7:0] bus;
    logic       conf;
    logic [3:0] opc;
    logic [7:0] outv;
    logic       fc;
    logic       fz;
  } exp_t;

  exp_t q[$];
  int   tag_q[$];
  int   n_checks = 0, n_fail = 0, step_no = 0;

  // Behavioural model state
  int m_pc = 0, m_mar = 0, m_mdr = 0, m_ir = 0, m_a = 0, m_b = 0, m_out = 0;
  bit m_fc = 0, m_fz = 0;
  int m_ram[16];

  task automatic check(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_fc = 0; m_fz = 0;
  endtask

  // Apply one control word for one clock; the expected outputs seen before the edge go to the scoreboard.
  task automatic step(input logic [14:0] c, input logic we = 1'b0, input logic [3:0] pa = 4'h0,
                      input logic [7:0] pd = 8'h00, input int want_bus = -1, input int want_conf = -1);
    int vals[$];
    int srcs[$];
    int bv, alu;
    exp_t e;
    @(negedge clk);
    ctrl = c; prog_we = we; prog_addr = pa; prog_data = pd;
    step_no++;
    alu = c[3] ? (m_a - m_b + 256) % 256 : (m_a + m_b) % 256;
    if (c[13])  begin vals.push_back(m_pc);       srcs.push_back(1); end
    if (!c[9])  begin vals.push_back(m_ram[m_mar]); srcs.push_back(2); end
    if (!c[6])  begin vals.push_back(m_ir % 16);  srcs.push_back(3); end
    if (c[4])   begin vals.push_back(m_a);        srcs.push_back(4); end
    if (c[2])   begin vals.push_back(alu);        srcs.push_back(5); end
    bv = vals.size() > 0 ? vals[0] : 0;
    e.bus  = want_bus >= 0 ? want_bus[7:0] : bv[7:0];
    e.conf = want_conf >= 0 ? want_conf[0] : (!rst && vals.size() > 1);
    e.opc  = rst ? 4'h0 : 4'(m_ir / 16);
    e.outv = rst ? 8'h00 : 8'(m_out);
    e.fc   = m_fc;
    e.fz   = m_fz;
    q.push_back(e);
    tag_q.push_back(step_no);
    if (!rst) begin
      if (!c[8] && !we) m_ram[m_mar] = m_mdr;
      if (!c[5] && srcs.size() > 0 && srcs[0] == 5) begin
        m_fc = c[3] ? (m_a >= m_b) : (m_a + m_b > 255);
        m_fz = (alu == 0);
      end
      m_pc  = c[12] ? bv % 16 : c[14] ? (m_pc + 1) % 16 : m_pc;
      if (!c[11]) m_mar = bv % 16;
      if (!c[10]) m_mdr = bv;
      if (!c[7])  m_ir  = bv;
      if (!c[5])  m_a   = bv;
      if (!c[1])  m_b   = bv;
      if (!c[0])  m_out = bv;
    end
    if (we) m_ram[pa] = int'(pd);
  endtask

  task automatic idle_release();
    @(negedge clk);
    rst = 1'b0; ctrl = NOP; prog_we = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the DUT outputs mid-cycle.
  initial begin
    exp_t e;
    int   t;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        t = tag_q.pop_front();
        check("bus", t, bus, e.bus);
        check("bus_conflict", t, {7'h0, bus_conflict}, {7'h0, e.conf});
        check("opcode", t, {4'h0, opcode}, {4'h0, e.opc});
        check("out_value", t, out_value, e.outv);
`ifdef DATAPATH_FLAGS_EN
        check("flag_c", t, {7'h0, flag_c}, {7'h0, e.fc});
        check("flag_z", t, {7'h0, flag_z}, {7'h0, e.fz});
`endif
      end
    end
  end

  initial begin
    logic [7:0] d;
    #1;
    check("reset_bus", 0, bus, 8'h00);
    check("reset_out", 0, out_value, 8'h00);
    // Program the whole RAM while reset is held; conflicting drivers must not flag in reset.
    for (int i = 0; i < 16; i++) begin
      d = i == 0 ? 8'h03 : i == 3 ? 8'h2A : 8'($urandom);
      step(NOP, 1'b1, 4'(i), d, 0, 0);
    end
    step(NOP ^ PC_EN ^ A_EN, 1'b0, 4'h0, 8'h00, 0, 0);
    idle_release();
    // MAR <- 3, then A <- RAM[3]
    step(NOP ^ RAM_EN ^ MAR_LD, 1'b0, 4'h0, 8'h00, 8'h03, 0);
    step(NOP ^ RAM_EN ^ A_LD, 1'b0, 4'h0, 8'h00, 8'h2A, 0);
    step(NOP ^ A_EN, 1'b0, 4'h0, 8'h00, 8'h2A, 0);
    // A = 5, B = 7, add then subtract through the ALU
    step(NOP, 1'b1, 4'h3, 8'h05, 8'h00, 0);
    step(NOP ^ RAM_EN ^ A_LD, 1'b0, 4'h0, 8'h00, 8'h05, 0);
    step(NOP, 1'b1, 4'h3, 8'h07, 8'h00, 0);
    step(NOP ^ RAM_EN ^ B_LD, 1'b0, 4'h0, 8'h00, 8'h07, 0);
    step(NOP ^ ALU_EN ^ SUB ^ A_LD, 1'b0, 4'h0, 8'h00, 8'hFE, 0);
    step(NOP ^ A_EN, 1'b0, 4'h0, 8'h00, 8'hFE, 0);
    step(NOP ^ ALU_EN ^ A_LD, 1'b0, 4'h0, 8'h00, 8'h05, 0);
    step(NOP ^ ALU_EN ^ SUB ^ A_LD, 1'b0, 4'h0, 8'h00, 8'hFE, 0);
    step(NOP ^ A_EN, 1'b0, 4'h0, 8'h00, 8'hFE, 0);
    // PC wrap and load-over-increment
    step(NOP, 1'b1, 4'h3, 8'h0F, 8'h00, 0);
    step(NOP ^ RAM_EN ^ PC_LD, 1'b0, 4'h0, 8'h00, 8'h0F, 0);
    step(NOP ^ PC_EN, 1'b0, 4'h0, 8'h00, 8'h0F, 0);
    step(NOP ^ PC_INC, 1'b0, 4'h0, 8'h00, 8'h00, 0);
    step(NOP ^ PC_EN, 1'b0, 4'h0, 8'h00, 8'h00, 0);
    step(NOP, 1'b1, 4'h3, 8'h09, 8'h00, 0);
    step(NOP ^ RAM_EN ^ PC_INC ^ PC_LD, 1'b0, 4'h0, 8'h00, 8'h09, 0);
    step(NOP ^ PC_EN, 1'b0, 4'h0, 8'h00, 8'h09, 0);
    // Two drivers: PC wins and conflict flags
    step(NOP ^ PC_EN ^ A_EN, 1'b0, 4'h0, 8'h00, 8'h09, 1);
    // A = 0x33, OUT and IR loaded
    step(NOP, 1'b1, 4'h3, 8'h33, 8'h00, 0);
    step(NOP ^ RAM_EN ^ A_LD, 1'b0, 4'h0, 8'h00, 8'h33, 0);
    step(NOP ^ RAM_EN ^ OUT_LD, 1'b0, 4'h0, 8'h00, 8'h33, 0);
    step(NOP ^ RAM_EN ^ IR_LD, 1'b0, 4'h0, 8'h00, 8'h33, 0);
    step(NOP ^ IR_EN, 1'b0, 4'h0, 8'h00, 8'h03, 0);
    // Asynchronous reset mid-cycle clears A without a clock edge
    @(negedge clk);
    ctrl = NOP ^ A_EN; prog_we = 1'b0;
    #1 check("a_before_rst", step_no, bus, 8'h33);
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("a_async_clr", step_no, bus, 8'h00);
    check("out_async_clr", step_no, out_value, 8'h00);
    check("opcode_async_clr", step_no, {4'h0, opcode}, 8'h00);
    step(NOP ^ RAM_EN, 1'b0, 4'h0, 8'h00, 8'h03, 0);
    step(NOP ^ PC_EN ^ RAM_EN, 1'b0, 4'h0, 8'h00, 8'h00, 0);
    idle_release();
    step(NOP ^ RAM_EN ^ MAR_LD, 1'b0, 4'h0, 8'h00, 8'h03, 0);
    step(NOP ^ RAM_EN, 1'b0, 4'h0, 8'h00, 8'h33, 0);
    step(NOP, 1'b0, 4'h0, 8'h00, 8'h00, 0);
    step(NOP ^ A_EN, 1'b0, 4'h0, 8'h00, 8'h00, 0);
    // Randomized control words against the model
    for (int i = 0; i < 400; i++)
      step(15'($urandom), ($urandom % 8) == 0, 4'($urandom), 8'($urandom));
    @(negedge clk);
    ctrl = NOP; prog_we = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_responder.md
DATAPATH_RESPONDER -- requirements
Module: datapath_responder

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ctrl  input  15  control word from the control block; bit map [14] PC_INC, [13] PC_EN, [12] PC_LOAD, [11] MAR_ADDR_LOAD_N, [10] MAR_MEM_LOAD_N, [9] RAM_EN_N, [8] RAM_LOAD_N, [7] IR_LOAD_N, [6] IR_EN_N, [5] REGA_LOAD_N, [4] REGA_EN, [3] ADDER_SUB, [2] ALU_EN, [1] REGB_LOAD_N, [0] OUT_LOAD_N; _N bits active-low.
REQ-004 SHALL have ports: prog_we  input  1, prog_addr  input  4, prog_data  input  8  external RAM programming.
REQ-005 SHALL have port: opcode  output  4  IR[7:4], returned to the control block.
REQ-006 SHALL have port: out_value  output  8  output register.
REQ-007 SHALL have port: bus  output  8  current bus value, for debug.
REQ-008 SHALL have port: bus_conflict  output  1  high when more than one bus driver is enabled.
REQ-009 SHALL have ports: flag_c, flag_z  output  1 each  when DATAPATH_FLAGS_EN is defined.

Function
REQ-010 SHALL sample ctrl on the rising edge of clk; ctrl changes on falling edge upstream, so no extra capture stage is allowed.
REQ-011 SHALL form bus combinationally; drivers: PC_EN -> {4'h0, PC}; !RAM_EN_N -> RAM[MAR]; !IR_EN_N -> {4'h0, IR[3:0]}; REGA_EN -> A; ALU_EN -> ALU result; no driver -> 8'h00.
REQ-012 SHALL resolve multiple drivers by fixed priority PC > RAM > IR > A > ALU and assert bus_conflict combinationally in the same cycle.
REQ-013 SHALL keep PC 4 bits; PC_INC adds 1 with wrap 15 -> 0; PC_LOAD loads bus[3:0]; PC_LOAD wins over PC_INC when both are set.
REQ-014 SHALL load MAR from bus[3:0] when MAR_ADDR_LOAD_N is low, and MDR from bus when MAR_MEM_LOAD_N is low.
REQ-015 SHALL write MDR into RAM[MAR] when RAM_LOAD_N is low; 16x8 RAM, read asynchronous.
REQ-016 SHALL let prog_we write prog_data to RAM[prog_addr], overriding RAM_LOAD_N in the same cycle, and shall accept prog_we while rst is high.
REQ-017 SHALL load IR, A, B and OUT from bus when their respective load bits are low.
REQ-018 SHALL compute ALU as A + B when ADDER_SUB = 0, and A + ~B + 1 when ADDER_SUB = 1, truncated to 8 bits with wrap.
REQ-019 SHALL use the value of a register written in a cycle only from the next cycle onward (read-old on simultaneous drive and load).
REQ-020 SHALL treat ctrl = 15'h0FE3 (all deasserted) as a no-op: no state changes.

Reset
REQ-021 SHALL clear PC, MAR, MDR, IR, A, B and OUT to 0 on rst assertion, asynchronously; flags shall also clear when present.
REQ-022 SHALL NOT clear RAM contents on reset; a mid-program reset preserves memory.
REQ-023 SHALL drive opcode = 4'h0, out_value = 8'h00 and bus_conflict = 0 while rst is high, regardless of ctrl.

Configuration
REQ-024 SHALL, with DATAPATH_FLAGS_EN defined, register flag_c (9th bit of the ALU sum; 1 = no borrow on subtract) and flag_z (ALU result == 0) whenever REGA_LOAD_N is low and ALU_EN is the selected driver.
REQ-025 SHALL, without DATAPATH_FLAGS_EN, omit flag_c, flag_z and their registers entirely.

Structure
REQ-026 SHALL place the ctrl bit-index constants, opcode constants and the no-op control word in a shared package, which the control block shall also use.
REQ-027 SHALL implement the 16x8 RAM plus its programming port as sub-module datapath_ram; all other logic stays in the top module.

Verification
REQ-028 SHALL cover: program RAM[3] = 8'h2A by prog_we under rst; then ctrl drives MAR <- 3 followed by A <- RAM -> A = 8'h2A, bus = 8'h2A.
REQ-029 SHALL cover: A = 8'h05, B = 8'h07, ADDER_SUB = 1, ALU_EN and REGA_LOAD_N low -> A = 8'hFE; with flags enabled, flag_c = 0 and flag_z = 0.
REQ-030 SHALL cover: PC = 4'hF, PC_INC -> PC = 4'h0; PC_INC together with PC_LOAD and bus = 8'h09 -> PC = 4'h9.
REQ-031 SHALL cover: PC_EN and REGA_EN asserted together -> bus = {4'h0, PC} and bus_conflict = 1 in the same cycle.
REQ-032 SHALL cover: rst pulsed mid-sequence with A = 8'h33 -> A = 0 immediately, without waiting for a clk edge, and RAM contents unchanged.
